// File: rtl/viterbi_job_arbiter.sv
// viterbi_job_arbiter: round-robin sharing of one viterbi decoder among N_REQ
// codeword sources, with a watchdog on each job and a valid/ready response port.
module viterbi_job_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7,
    localparam int unsigned CW_W   = 16,
    localparam int unsigned BYTE_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [CW_W*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   dec_en,
    output logic [CW_W-1:0]        dec_data,
    input  logic [BYTE_W-1:0]      dec_odata,
    input  logic                   dec_done,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [BYTE_W-1:0]      rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [BYTE_W-1:0]      err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t           state;
    logic [ID_W-1:0]  last_gnt;
    logic [CNT_W-1:0] wdog;

    logic             found;
    logic [ID_W-1:0]  gnt_idx;
    logic [CW_W-1:0]  sel_data;

    // Round-robin pick: first valid requester after the last one served.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req_valid[i] && (((int'(last_gnt) + k) % N_REQ) == i)) begin
                    found   = 1'b1;
                    gnt_idx = ID_W'(i);
                end
            end
        end
    end

    // Codeword of the selected requester.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_data = req_data[CW_W*i +: CW_W];
            end
        end
    end

    // Accept pulse is asserted in the transfer cycle itself, so it follows req_valid.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (state == IDLE && found && gnt_idx == ID_W'(i)) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    // Job sequencer: grant, run decoder under watchdog, respond, one idle gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_gnt  <= ID_W'(N_REQ - 1);
            wdog      <= '0;
            dec_en    <= 1'b0;
            dec_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            err_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        dec_data <= sel_data;
                        rsp_id   <= gnt_idx;
                        wdog     <= '0;
                        dec_en   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    wdog <= wdog + CNT_W'(1);
                    if (dec_done) begin
                        rsp_data  <= dec_odata;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        dec_en    <= 1'b0;
                        state     <= RESP;
                    end else if (wdog == CNT_W'(TIMEOUT - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        dec_en    <= 1'b0;
                        if (err_cnt != {BYTE_W{1'b1}}) begin
                            err_cnt <= err_cnt + BYTE_W'(1);
                        end
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        last_gnt  <= rsp_id;
                        wdog      <= '0;
                        rsp_valid <= 1'b0;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_job_arbiter.sv
// Scoreboard bench for viterbi_job_arbiter with requester, decoder and sink models.
module tb_viterbi_job_arbiter;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 7;
    localparam int NEVER   = 100000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N_REQ-1:0]     req_valid;
    logic [16*N_REQ-1:0]  req_data;
    logic [N_REQ-1:0]     req_ready;
    logic                 dec_en;
    logic [15:0]          dec_data;
    logic [7:0]           dec_odata;
    logic                 dec_done;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [7:0]           rsp_data;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_err;
    logic                 busy;
    logic [7:0]           err_cnt;

    always #5 clk = ~clk;

    viterbi_job_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .dec_en(dec_en), .dec_data(dec_data), .dec_odata(dec_odata), .dec_done(dec_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy), .err_cnt(err_cnt)
    );

    typedef struct { logic [15:0] cw; logic [7:0] od; int lat; } job_t;
    typedef struct { int id; logic [7:0] data; logic err; int ecnt; } exp_t;
    typedef enum { M_IDLE, M_BUSY, M_GAP } mstate_t;

    int       n_chk = 0;
    int       n_fail = 0;
    job_t     cur_job [N_REQ];
    int       remaining [N_REQ];
    logic [N_REQ-1:0] pend = '0;
    exp_t     sbq [$];
    int       hist [$];
    int       ptr = N_REQ - 1;
    mstate_t  mstate = M_IDLE;
    int       err_model = 0;
    job_t     run_job;
    int       run_cyc = 0;
    logic     prev_en = 1'b0;
    int       lat_mode = 2;
    int       rr_mode = 0;
    logic     spur = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    function automatic job_t mk(input int lat);
        job_t j;
        j.cw  = 16'($urandom);
        j.od  = 8'($urandom);
        j.lat = lat;
        return j;
    endfunction

    // lat_mode 0: mixed incl. watchdog corners, 1: never done, 2: short
    function automatic job_t gen_job();
        int r;
        r = int'($urandom_range(0, 9));
        if (lat_mode == 1) return mk(NEVER);
        if (lat_mode == 2) return mk(int'($urandom_range(1, 12)));
        case (r)
            0:       return mk(TIMEOUT - 1);
            1:       return mk(TIMEOUT);
            2:       return mk(TIMEOUT + 1 + int'($urandom_range(0, 5)));
            default: return mk(int'($urandom_range(1, 25)));
        endcase
    endfunction

    function automatic void present(input int i, input job_t j);
        cur_job[i] = j;
        req_data[16*i +: 16] = j.cw;
        req_valid[i] = 1'b1;
    endfunction

    function automatic int rr_pick(input logic [N_REQ-1:0] v, input int last);
        int c;
        for (int k = 1; k <= N_REQ; k++) begin
            c = (last + k) % N_REQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Environment: sink, decoder model, requester reloads, grant/busy/response checks.
    initial begin : env
        int g;
        logic [N_REQ-1:0] exp_rdy;
        logic hs;
        int hs_id;
        int exp_len;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mstate = M_IDLE; ptr = N_REQ - 1; sbq.delete(); err_model = 0;
                run_cyc = 0; prev_en = 1'b0; pend = '0; dec_done = 1'b0;
            end else begin
                case (rr_mode)
                    0:       rsp_ready = 1'b1;
                    1:       rsp_ready = 1'($urandom_range(0, 1));
                    default: rsp_ready = 1'b0;
                endcase
                g = (mstate == M_IDLE) ? rr_pick(req_valid, ptr) : -1;
                exp_rdy = (g >= 0) ? (N_REQ'(1) << g) : '0;
                chk("req_ready", int'(req_ready), int'(exp_rdy));
                chk("busy", int'(busy), (mstate != M_IDLE) ? 1 : 0);

                hs = 1'b0; hs_id = 0;
                if (rsp_valid) begin
                    chk("dec_en_in_resp", int'(dec_en), 0);
                    n_chk++;
                    if (sbq.size() == 0) begin
                        n_fail++;
                        $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d expected no response", rsp_id);
                    end else begin
                        e = sbq[0];
                        if (rsp_data !== e.data || int'(rsp_id) != e.id || rsp_err !== e.err || int'(err_cnt) != e.ecnt) begin
                            n_fail++;
                            $display("FAIL rsp: got data=%h id=%0d err=%0b err_cnt=%0d expected data=%h id=%0d err=%0b err_cnt=%0d",
                                     rsp_data, rsp_id, rsp_err, err_cnt, e.data, e.id, e.err, e.ecnt);
                        end
                        if (rsp_ready) begin
                            void'(sbq.pop_front());
                            hs = 1'b1; hs_id = e.id;
                        end
                    end
                end

                if (dec_en) begin
                    run_cyc++;
                    if (run_cyc == 1) chk("dec_data", int'(dec_data), int'(run_job.cw));
                    dec_done  = (run_cyc == run_job.lat);
                    dec_odata = dec_done ? run_job.od : 8'($urandom);
                end else begin
                    if (prev_en) begin
                        exp_len = (run_job.lat < TIMEOUT) ? run_job.lat : TIMEOUT;
                        chk("dec_en_len", run_cyc, exp_len);
                    end
                    dec_done  = spur ? 1'($urandom_range(0, 1)) : 1'b0;
                    dec_odata = 8'($urandom);
                end
                prev_en = dec_en;

                for (int i = 0; i < N_REQ; i++) begin
                    if (pend[i]) begin
                        pend[i] = 1'b0;
                        if (remaining[i] > 0) begin
                            remaining[i]--;
                            present(i, gen_job());
                        end else begin
                            req_valid[i] = 1'b0;
                        end
                    end
                end

                case (mstate)
                    M_IDLE: if (g >= 0) begin
                        e.id = g;
                        e.err = (cur_job[g].lat > TIMEOUT);
                        e.data = e.err ? 8'h00 : cur_job[g].od;
                        if (e.err && err_model < 255) err_model++;
                        e.ecnt = err_model;
                        sbq.push_back(e);
                        run_job = cur_job[g];
                        run_cyc = 0;
                        pend[g] = 1'b1;
                        hist.push_back(g);
                        mstate = M_BUSY;
                    end
                    M_BUSY: if (hs) begin
                        ptr = hs_id;
                        mstate = M_GAP;
                    end
                    default: mstate = M_IDLE;
                endcase
            end
        end
    end

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (!(req_valid == '0 && sbq.size() == 0 && mstate == M_IDLE && pend == '0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        n_chk++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_hist(input string name, input int exp_q[$]);
        chk({name, "_len"}, hist.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < hist.size(); i++) chk(name, hist[i], exp_q[i]);
    endtask

    initial begin : stim
        int n;
        req_valid = '0; req_data = '0; dec_done = 1'b0; dec_odata = '0; rsp_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin remaining[i] = 0; cur_job[i] = mk(1); end
        run_job = mk(1);
        #1 rst = 1'b0;
        #6;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_dec_en", int'(dec_en), 0);
        chk("rst_dec_data", int'(dec_data), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_fields", int'({rsp_data, rsp_id, rsp_err}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // single job, done after 20 cycles
        present(0, '{16'hB5A3, 8'h5C, 20});
        wait_idle(200, "t1");

        // round robin over all requesters
        hist.delete();
        present(3, mk(5));
        wait_idle(100, "t2a");
        remaining[0] = 1;
        for (int i = 0; i < N_REQ; i++) present(i, mk(int'($urandom_range(1, 8))));
        wait_idle(400, "t2b");
        chk_hist("t2_order", '{3, 0, 1, 2, 3, 0});
        hist.delete();
        present(2, mk(4));
        wait_idle(100, "t2c");
        present(0, mk(3)); present(1, mk(6)); present(3, mk(2));
        wait_idle(200, "t2d");
        chk_hist("t2_rotate", '{2, 3, 0, 1});

        // watchdog abort, then a normal job
        present(1, mk(NEVER));
        wait_idle(300, "t3a");
        present(1, mk(7));
        wait_idle(100, "t3b");

        // response backpressure with another requester waiting
        rr_mode = 2;
        present(2, mk(5)); present(3, mk(4));
        n = 0;
        while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("t4_rsp_seen", (n < 100) ? 1 : 0, 1);
        repeat (10) @(posedge clk);
        #1 chk("t4_hold_valid", int'(rsp_valid), 1);
        rr_mode = 0;
        wait_idle(200, "t4");

        // done on the last watchdog cycle, one past it, and done pulses while idle
        spur = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        present(0, mk(TIMEOUT));
        wait_idle(300, "t5a");
        present(0, mk(TIMEOUT + 1));
        wait_idle(300, "t5b");

        // randomized traffic with random backpressure
        lat_mode = 0; rr_mode = 1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    remaining[i] = int'($urandom_range(0, 4));
                    present(i, gen_job());
                end else begin
                    remaining[i] = 0;
                end
            end
            wait_idle(20000, "rand");
        end

        // error counter saturation
        spur = 1'b0; rr_mode = 0; lat_mode = 1;
        remaining[0] = 259;
        present(0, gen_job());
        wait_idle(40000, "sat");
        chk("sat_err_cnt", int'(err_cnt), 255);

        // reset in the middle of a job
        lat_mode = 2;
        present(1, mk(NEVER));
        n = 0;
        while (!dec_en && n < 50) begin @(posedge clk); #1; n++; end
        chk("t6_run_seen", (n < 50) ? 1 : 0, 1);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N_REQ; i++) remaining[i] = 0;
        #1;
        chk("t6_dec_en", int'(dec_en), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_rsp_valid", int'(rsp_valid), 0);
        chk("t6_err_cnt", int'(err_cnt), 0);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        hist.delete();
        for (int i = 0; i < N_REQ; i++) present(i, mk(3));
        wait_idle(200, "t6");
        chk_hist("t6_order", '{0, 1, 2, 3});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : guard
        #3000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

endmodule
